// File: rtl/schematic_pkg.sv
// Shared constants for the schematic RV32I-subset core.
package schematic_pkg;

  // Major opcodes handled by the core
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct7 selecting SUB / SRA(I); only bit 30 of the instruction matters
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Memory operation codes on MEM_OP
  localparam logic [1:0] MOP_IDLE  = 2'd0;
  localparam logic [1:0] MOP_STORE = 2'd1;
  localparam logic [1:0] MOP_LOAD  = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/schematic_regfile.sv
// 32-entry register file: two async read ports, one sync write port, x0 hardwired to 0.
module schematic_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [31:0][XLEN-1:0] regs_q, regs_d;

  // Next register contents; writes to x0 are dropped
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  // Register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/schematic.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC -> (MEM_WAIT) -> FETCH.
module schematic
  import schematic_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          XLEN     = 32
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [31:0]     ADDR,
  input  logic [31:0]     MEM_INST,
  input  logic            MEM_INST_ENB,
  output logic [1:0]      MEM_OP,
  output logic [15:0]     MEM_ADDR,
  output logic [XLEN-1:0] MEM_STORE,
  input  logic [XLEN-1:0] MEM_LOAD,
  input  logic            READ_READY,
  input  logic            MEM_WRITEENABLE
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic       f7_alt;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7_alt = ir_q[30] == F7_ALT[5];

  logic [XLEN-1:0] imm_i, imm_s;
  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};

  logic            is_op_imm, is_op, is_load, is_store;
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_load   = (opcode == OPC_LOAD) &&
                     (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
  assign is_store  = (opcode == OPC_STORE) &&
                     (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);

  logic [XLEN-1:0] rs1_v, rs2_v;
  logic            rf_we;
  logic [XLEN-1:0] rf_wd;

  schematic_regfile #(.XLEN(XLEN)) u_rf (
    .clk (CLK),
    .rst (RST),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_v),
    .rd2 (rs2_v),
    .we  (rf_we),
    .wa  (rd),
    .wd  (rf_wd)
  );

  // ALU shared by OP and OP-IMM; only register-register ADD can become SUB
  logic [XLEN-1:0] alu_b, alu_res;
  logic [4:0]      shamt;
  always_comb begin
    alu_b   = is_op ? rs2_v : imm_i;
    shamt   = alu_b[4:0];
    alu_res = '0;
    case (f3)
      F3_ADD:  alu_res = (is_op && f7_alt) ? rs1_v - alu_b : rs1_v + alu_b;
      F3_SLL:  alu_res = rs1_v << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_v) < $signed(alu_b)};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_v < alu_b};
      F3_XOR:  alu_res = rs1_v ^ alu_b;
      F3_SR:   alu_res = f7_alt ? $unsigned($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      F3_OR:   alu_res = rs1_v | alu_b;
      F3_AND:  alu_res = rs1_v & alu_b;
      default: alu_res = '0;
    endcase
  end

  // Data address is only 16 bits wide, so only the low half is summed
  logic [15:0] agen;
  assign agen = rs1_v[15:0] + (is_store ? imm_s[15:0] : imm_i[15:0]);

  // Load extension and store formatting; memory is word-per-address, no lane shifts
  logic [XLEN-1:0] load_ext, store_fmt;
  always_comb begin
    load_ext = '0;
    case (f3)
      F3_LB:   load_ext = {{(XLEN-8){MEM_LOAD[7]}}, MEM_LOAD[7:0]};
      F3_LH:   load_ext = {{(XLEN-16){MEM_LOAD[15]}}, MEM_LOAD[15:0]};
      F3_LW:   load_ext = MEM_LOAD;
      F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, MEM_LOAD[7:0]};
      F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, MEM_LOAD[15:0]};
      default: load_ext = '0;
    endcase
    store_fmt = rs2_v;
    case (f3)
      F3_SB:   store_fmt = {{(XLEN-8){1'b0}}, rs2_v[7:0]};
      F3_SH:   store_fmt = {{(XLEN-16){1'b0}}, rs2_v[15:0]};
      default: store_fmt = rs2_v;
    endcase
  end

  // FSM next state, PC/IR update, register write and memory interface outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    rf_we     = 1'b0;
    rf_wd     = alu_res;
    MEM_OP    = MOP_IDLE;
    MEM_ADDR  = '0;
    MEM_STORE = '0;
    case (state_q)
      ST_FETCH: begin
        if (MEM_INST_ENB) begin
          ir_d    = MEM_INST;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load) begin
          MEM_OP   = MOP_LOAD;
          MEM_ADDR = agen;
          state_d  = ST_MEM_WAIT;
        end else begin
          // ALU ops write rd; stores and anything unsupported only advance the PC
          rf_we   = is_op_imm || is_op;
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
          if (is_store) begin
            MEM_OP    = MOP_STORE;
            MEM_ADDR  = agen;
            MEM_STORE = store_fmt;
          end
        end
      end
      ST_MEM_WAIT: begin
        MEM_OP   = MOP_LOAD;
        MEM_ADDR = agen;
        if (READ_READY) begin
          rf_we   = MEM_WRITEENABLE;
          rf_wd   = load_ext;
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Core state registers; reset abandons any outstanding access
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign ADDR = pc_q;

endmodule

// File: tb/tb_schematic.sv
// Self-checking bench for schematic: directed vector table, hand sequences, and
// random programs checked against an instruction-level ISA model.
module tb_schematic;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ADDR;
  logic [31:0] MEM_INST;
  logic        MEM_INST_ENB;
  logic [1:0]  MEM_OP;
  logic [15:0] MEM_ADDR;
  logic [31:0] MEM_STORE;
  logic [31:0] MEM_LOAD;
  logic        READ_READY;
  logic        MEM_WRITEENABLE;

  always #5 CLK = ~CLK;

  schematic dut (
    .CLK             (CLK),
    .RST             (RST),
    .ADDR            (ADDR),
    .MEM_INST        (MEM_INST),
    .MEM_INST_ENB    (MEM_INST_ENB),
    .MEM_OP          (MEM_OP),
    .MEM_ADDR        (MEM_ADDR),
    .MEM_STORE       (MEM_STORE),
    .MEM_LOAD        (MEM_LOAD),
    .READ_READY      (READ_READY),
    .MEM_WRITEENABLE (MEM_WRITEENABLE)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] mregs [32];

  typedef struct {
    logic [31:0] inst;
    int          stall;
    int          rrw;
    logic [31:0] ldata;
    bit          we;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] store;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h pc=%h", nm, act, exp, exp_pc);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Enter at a negedge in FETCH; present one instruction and follow it back to FETCH
  task automatic run_instr(input logic [31:0] inst, input int stall, input int rrw,
                           input logic [31:0] ldata, input bit we, input logic [1:0] eop,
                           input logic [15:0] eaddr, input logic [31:0] estore);
    chk("fetch_addr", ADDR, exp_pc);
    chk("fetch_memop", {30'b0, MEM_OP}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      MEM_INST_ENB = 1'b0;
      MEM_INST     = $urandom;
      @(negedge CLK);
      chk("stall_addr", ADDR, exp_pc);
      chk("stall_memop", {30'b0, MEM_OP}, 32'd0);
    end
    MEM_INST     = inst;
    MEM_INST_ENB = 1'b1;
    @(negedge CLK);
    MEM_INST_ENB = 1'b0;
    chk("exec_memop", {30'b0, MEM_OP}, {30'b0, eop});
    if (eop != 2'd0) chk("exec_memaddr", {16'b0, MEM_ADDR}, {16'b0, eaddr});
    if (eop == 2'd1) chk("exec_store", MEM_STORE, estore);
    if (eop == 2'd2) begin
      @(negedge CLK);
      for (int w = 0; w < rrw; w++) begin
        chk("wait_memop", {30'b0, MEM_OP}, 32'd2);
        MEM_LOAD = $urandom;
        @(negedge CLK);
      end
      chk("wait_memop", {30'b0, MEM_OP}, 32'd2);
      chk("wait_memaddr", {16'b0, MEM_ADDR}, {16'b0, eaddr});
      MEM_LOAD        = ldata;
      MEM_WRITEENABLE = we;
      READ_READY      = 1'b1;
      @(negedge CLK);
      READ_READY      = 1'b0;
      MEM_WRITEENABLE = 1'($urandom_range(0, 1));
    end else begin
      @(negedge CLK);
    end
    exp_pc = exp_pc + 32'd4;
  endtask

  // Instruction-level reference: returns the expected bus activity, updates model regs
  task automatic model_step(input logic [31:0] inst, input logic [31:0] ld, input bit we,
                            output logic [1:0] op, output logic [15:0] addr,
                            output logic [31:0] st);
    logic [31:0] a, b, ii, is, y, res, sum;
    logic [2:0]  f3;
    logic [4:0]  sh;
    bit          wr;
    a   = mregs[inst[19:15]];
    b   = mregs[inst[24:20]];
    ii  = {{20{inst[31]}}, inst[31:20]};
    is  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    f3  = inst[14:12];
    wr  = 1'b0;
    res = 32'd0;
    op  = 2'd0;
    addr = 16'd0;
    st  = 32'd0;
    case (inst[6:0])
      7'h13, 7'h33: begin
        y  = (inst[6:0] == 7'h33) ? b : ii;
        sh = y[4:0];
        wr = 1'b1;
        case (f3)
          3'd0: res = (inst[6:0] == 7'h33 && inst[30]) ? a - y : a + y;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: res = (a < y) ? 32'd1 : 32'd0;
          3'd4: res = a ^ y;
          3'd5: res = inst[30] ? $unsigned($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | y;
          default: res = a & y;
        endcase
      end
      7'h03: begin
        if (f3 != 3'd3 && f3 < 3'd6) begin
          sum  = a + ii;
          op   = 2'd2;
          addr = sum[15:0];
          wr   = we;
          case (f3)
            3'd0:    res = {{24{ld[7]}}, ld[7:0]};
            3'd1:    res = {{16{ld[15]}}, ld[15:0]};
            3'd2:    res = ld;
            3'd4:    res = ld & 32'h0000_00FF;
            default: res = ld & 32'h0000_FFFF;
          endcase
        end
      end
      7'h23: begin
        if (f3 < 3'd3) begin
          sum  = a + is;
          op   = 2'd1;
          addr = sum[15:0];
          st   = (f3 == 3'd0) ? (b & 32'hFF) : (f3 == 3'd1) ? (b & 32'hFFFF) : b;
        end
      end
      default: ;
    endcase
    if (wr && inst[11:7] != 5'd0) mregs[inst[11:7]] = res;
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [31:0] r;
    k   = $urandom_range(0, 9);
    f3  = 3'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    if (k <= 2) begin
      if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
      if (f3 == 3'd5) imm = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, imm[4:0]};
      return enc_i(imm, rs1, f3, rd, 7'b0010011);
    end else if (k <= 5) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      return enc_r(f7, rs2, rs1, f3, rd);
    end else if (k <= 7) begin
      return enc_i(imm, rs1, f3, rd, 7'b0000011);
    end else if (k == 8) begin
      return enc_s(imm, rs2, rs1, f3);
    end
    r      = $urandom;
    r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h37;
    return r;
  endfunction

  initial begin
    logic [31:0] inst, ld;
    logic [1:0]  eop;
    logic [15:0] eaddr;
    logic [31:0] est;
    bit          we;

    // Directed vectors: {inst, stall, ready wait, load data, we, MEM_OP, MEM_ADDR, MEM_STORE}
    tbl[0]  = '{enc_i(12'd31, 5'd0, 3'd4, 5'd31, 7'h03), 5, 0, 32'h31, 1'b1, 2'd2, 16'd31, 32'h0};
    tbl[1]  = '{enc_i(12'd31, 5'd0, 3'd0, 5'd30, 7'h13), 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[2]  = '{enc_i(12'd1, 5'd31, 3'd0, 5'd31, 7'h13), 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[3]  = '{enc_s(12'd0, 5'd31, 5'd30, 3'd0), 0, 0, 32'h0, 1'b1, 2'd1, 16'd31, 32'h32};
    tbl[4]  = '{enc_i(12'd0, 5'd0, 3'd0, 5'd5, 7'h03), 0, 2, 32'hF0, 1'b1, 2'd2, 16'd0, 32'h0};
    tbl[5]  = '{enc_s(12'd4, 5'd5, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd4, 32'hFFFF_FFF0};
    tbl[6]  = '{enc_i(12'd0, 5'd0, 3'd4, 5'd6, 7'h03), 0, 1, 32'hF0, 1'b1, 2'd2, 16'd0, 32'h0};
    tbl[7]  = '{enc_s(12'd8, 5'd6, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd8, 32'hF0};
    tbl[8]  = '{enc_i(12'd0, 5'd0, 3'd2, 5'd6, 7'h03), 0, 0, 32'h1234_5678, 1'b0, 2'd2, 16'd0, 32'h0};
    tbl[9]  = '{enc_s(12'd8, 5'd6, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd8, 32'hF0};
    tbl[10] = '{enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[11] = '{enc_s(12'd12, 5'd0, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd12, 32'h0};
    tbl[12] = '{32'hFFFF_FFFF, 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[13] = '{enc_s(12'd0, 5'd5, 5'd0, 3'd1), 0, 0, 32'h0, 1'b1, 2'd1, 16'd0, 32'h0000_FFF0};
    tbl[14] = '{enc_i(12'hFFE, 5'd31, 3'd1, 5'd7, 7'h03), 0, 0, 32'h0000_8001, 1'b1, 2'd2, 16'h30, 32'h0};
    tbl[15] = '{enc_s(12'd0, 5'd7, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd0, 32'hFFFF_8001};
    tbl[16] = '{enc_i(12'd0, 5'd0, 3'd5, 5'd7, 7'h03), 0, 0, 32'h0000_8001, 1'b1, 2'd2, 16'd0, 32'h0};
    tbl[17] = '{enc_s(12'd0, 5'd7, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd0, 32'h0000_8001};
    tbl[18] = '{enc_r(7'h20, 5'd31, 5'd0, 3'd0, 5'd8), 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[19] = '{enc_s(12'd0, 5'd8, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd0, 32'hFFFF_FFCE};
    tbl[20] = '{enc_i(12'h404, 5'd8, 3'd5, 5'd9, 7'h13), 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[21] = '{enc_s(12'd0, 5'd9, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd0, 32'hFFFF_FFFC};
    tbl[22] = '{enc_s(12'd16, 5'd1, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd16, 32'h0};
    tbl[23] = '{enc_i(12'hFFF, 5'd0, 3'd3, 5'd10, 7'h13), 0, 0, 32'h0, 1'b1, 2'd0, 16'd0, 32'h0};
    tbl[24] = '{enc_s(12'd0, 5'd10, 5'd0, 3'd2), 0, 0, 32'h0, 1'b1, 2'd1, 16'd0, 32'h1};

    // Reset held two edges with a valid instruction offered: nothing may be fetched
    RST             = 1'b1;
    MEM_INST        = enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13);
    MEM_INST_ENB    = 1'b1;
    MEM_LOAD        = 32'h0;
    READ_READY      = 1'b0;
    MEM_WRITEENABLE = 1'b1;
    exp_pc          = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_addr", ADDR, 32'h0);
      chk("rst_memop", {30'b0, MEM_OP}, 32'd0);
      chk("rst_memaddr", {16'b0, MEM_ADDR}, 32'd0);
      chk("rst_store", MEM_STORE, 32'd0);
    end
    MEM_INST_ENB = 1'b0;
    RST          = 1'b0;

    // Directed table
    for (int i = 0; i < 25; i++)
      run_instr(tbl[i].inst, tbl[i].stall, tbl[i].rrw, tbl[i].ldata, tbl[i].we,
                tbl[i].op, tbl[i].addr, tbl[i].store);

    // Reset arriving while a load waits for READ_READY
    MEM_INST     = enc_i(12'd3, 5'd0, 3'd2, 5'd5, 7'h03);
    MEM_INST_ENB = 1'b1;
    @(negedge CLK);
    MEM_INST_ENB = 1'b0;
    chk("rstld_exec_memop", {30'b0, MEM_OP}, 32'd2);
    @(negedge CLK);
    chk("rstld_wait_memop", {30'b0, MEM_OP}, 32'd2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstld_memop", {30'b0, MEM_OP}, 32'd0);
    chk("rstld_addr", ADDR, 32'h0);
    chk("rstld_memaddr", {16'b0, MEM_ADDR}, 32'd0);
    exp_pc = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

    // Random program against the ISA model
    for (int n = 0; n < 300; n++) begin
      inst = rand_instr();
      ld   = $urandom;
      we   = ($urandom_range(0, 4) != 0);
      model_step(inst, ld, we, eop, eaddr, est);
      run_instr(inst, $urandom_range(0, 2), $urandom_range(0, 2), ld, we, eop, eaddr, est);
    end

    // Dump every register through a store and compare with the model
    for (int r = 0; r < 32; r++) begin
      inst = enc_s(12'd0, 5'(r), 5'd0, 3'd2);
      model_step(inst, 32'h0, 1'b0, eop, eaddr, est);
      run_instr(inst, 0, 0, 32'h0, 1'b0, eop, eaddr, est);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
